// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared constants for the LED sequencer.
//   MODE_*  : 2-bit pattern mode encodings driven on led_sequencer.mode
//   PWM_W   : width of the PWM counter and of the duty input
//   dir_e   : bounce direction
package led_seq_pkg;
    localparam logic [1:0] MODE_ROT_L  = 2'd0;
    localparam logic [1:0] MODE_ROT_R  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;
    localparam int PWM_W = 8;
    typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_e;
endpackage

// File: rtl/led_seq_presc.sv
// led_seq_presc: programmable prescaler producing one tick every period+1 enabled cycles.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : advance the counter when high
//   clr        : force count to 0 and suppress the tick (mode-change reload)
//   period     : terminal count; tick when count >= period
//   count      : current prescaler value
//   tick       : combinational strobe, high when this edge wraps the counter
module led_seq_presc
    import led_seq_pkg::*;
#(
    parameter int PRESC_W = 27
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] period,
    output logic [PRESC_W-1:0] count,
    output logic               tick
);
    // >= rather than == so that lowering period below count wraps immediately
    assign tick = en && !clr && (count >= period);

    always_ff @(posedge clk) begin
        if (!rst_n || clr || tick)
            count <= '0;
        else if (en)
            count <= count + PRESC_W'(1);
    end
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: LED pattern generator (rotate left/right, bounce, binary count).
//   clk, rst_n : clock, synchronous active-low reset
//   en         : 1 = run, 0 = freeze prescaler and pattern
//   mode       : MODE_ROT_L / MODE_ROT_R / MODE_BOUNCE / MODE_COUNT
//   period     : one pattern step every period+1 cycles
//   duty       : PWM brightness, only used when LED_SEQ_PWM_EN is defined
//   led        : pattern, PWM-gated when LED_SEQ_PWM_EN is defined
//   step       : registered pulse, high in the cycle the pattern updates
//   count      : prescaler value
// Optional feature: define LED_SEQ_PWM_EN to build the PWM brightness gate.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 27
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [PRESC_W-1:0] period,
    input  logic [PWM_W-1:0]   duty,
    output logic [WIDTH-1:0]   led,
    output logic               step,
    output logic [PRESC_W-1:0] count
);
    logic [WIDTH-1:0] pattern, pattern_nxt;
    dir_e             dir, dir_nxt;
    logic [1:0]       mode_q;
    logic             tick;
    logic             reload;

    // A mode change restarts everything and outranks both tick and en
    assign reload = mode != mode_q;

    led_seq_presc #(.PRESC_W(PRESC_W)) presc (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .clr    (reload),
        .period (period),
        .count  (count),
        .tick   (tick)
    );

    always_comb begin
        pattern_nxt = pattern;
        dir_nxt     = dir;
        case (mode_q)
            MODE_ROT_L: pattern_nxt = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
            MODE_ROT_R: pattern_nxt = {pattern[0], pattern[WIDTH-1:1]};
            MODE_BOUNCE: begin
                pattern_nxt = (dir == DIR_LEFT) ? pattern << 1 : pattern >> 1;
                // flip as the bit lands on an end so it is never held there twice
                dir_nxt = pattern_nxt[WIDTH-1] ? DIR_RIGHT :
                          pattern_nxt[0]       ? DIR_LEFT  : dir;
            end
            default: pattern_nxt = pattern + WIDTH'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || reload) begin
            mode_q  <= mode;
            pattern <= WIDTH'(1);
            dir     <= DIR_LEFT;
            step    <= 1'b0;
        end else begin
            step <= tick;
            if (tick) begin
                pattern <= pattern_nxt;
                dir     <= dir_nxt;
            end
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + PWM_W'(1);
    end

    assign led = pattern & {WIDTH{pwm_cnt < duty}};
`else
    logic duty_unused;
    assign duty_unused = ^duty;
    assign led = pattern;
`endif
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed plus randomized checks of led_sequencer against a tick-count model.
module tb_led_sequencer;
    localparam int W  = 8;
    localparam int PW = 27;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          en     = 1'b1;
    logic [1:0]    mode   = 2'd0;
    logic [PW-1:0] period = PW'(3);
    logic [7:0]    duty   = 8'd64;
    logic [W-1:0]  led;
    logic          step;
    logic [PW-1:0] count;

    int n_asrt = 0;
    int n_fail = 0;

    // Model state: mode, ticks since last reload, prescaler, step, pwm counter
    int m_mode = 0;
    int m_t    = 0;
    int m_cnt  = 0;
    int m_pwm  = 0;
    bit m_step = 1'b0;

    always #5 clk = ~clk;

    led_sequencer #(.WIDTH(W), .PRESC_W(PW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .mode   (mode),
        .period (period),
        .duty   (duty),
        .led    (led),
        .step   (step),
        .count  (count)
    );

    // Pattern after t ticks from the one-hot start, derived from the mode rules
    function automatic logic [W-1:0] model_pat(int md, int t);
        int b;
        case (md)
            0: return W'(1 << (t % W));
            1: return W'(1 << ((W - t % W) % W));
            2: begin
                b = t % (2 * W - 2);
                return W'(1 << ((b < W) ? b : 2 * W - 2 - b));
            end
            default: return W'(t + 1);
        endcase
    endfunction

    function automatic logic [W-1:0] model_led();
`ifdef LED_SEQ_PWM_EN
        return (m_pwm < int'(duty)) ? model_pat(m_mode, m_t) : '0;
`else
        return model_pat(m_mode, m_t);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        if (!rst_n) begin
            m_mode = int'(mode); m_t = 0; m_cnt = 0; m_step = 1'b0; m_pwm = 0;
        end else begin
            m_pwm = (m_pwm + 1) % 256;
            if (int'(mode) != m_mode) begin
                m_mode = int'(mode); m_t = 0; m_cnt = 0; m_step = 1'b0;
            end else if (en) begin
                if (m_cnt >= int'(period)) begin
                    m_cnt = 0; m_t++; m_step = 1'b1;
                end else begin
                    m_cnt++; m_step = 1'b0;
                end
            end else
                m_step = 1'b0;
        end
        #1;
        chk({tag, ".led"},   32'(led),   32'(model_led()));
        chk({tag, ".step"},  32'(step),  32'(m_step));
        chk({tag, ".count"}, 32'(count), 32'(m_cnt));
    endtask

    initial begin
        // reset state
        repeat (2) cyc("reset");
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_step",  32'(step),  32'd0);
        chk("rst_led",   32'(led),   32'd1);
        rst_n = 1'b1;
        // ROT_L, period 3: four cycles per step, full wrap
        repeat (40) cyc("rotl");
        // ROT_R one step per cycle
        mode = 2'd1; period = '0;
        repeat (20) cyc("rotr");
        // BOUNCE through both ends
        mode = 2'd2;
        repeat (30) cyc("bounce");
        // COUNT through 0xFE -> 0xFF -> 0x00 with a freeze in the middle
        mode = 2'd3;
        repeat (200) cyc("count");
        en = 1'b0;
        repeat (10) cyc("frozen");
        en = 1'b1;
        repeat (70) cyc("count2");
        // lowering period below count wraps on the next edge
        mode = 2'd0;
        cyc("reload");
        period = PW'(100);
        repeat (50) cyc("p100");
        chk("p100_count50", 32'(count), 32'd50);
        period = PW'(10);
        cyc("p10");
        chk("shrink_count", 32'(count), 32'd0);
        chk("shrink_step",  32'(step),  32'd1);
        // mode change coinciding with a tick edge
        period = PW'(2);
        for (int i = 0; i < 10 && m_cnt < 2; i++) cyc("seek");
        chk("seek_done", 32'(count), 32'd2);
        mode = 2'd2;
        cyc("modetick");
        chk("modetick_step", 32'(step), 32'd0);
        chk("modetick_led",  32'(led),  32'(model_pat(2, 0) & model_led()));
        // randomized mix of enable, mode, period and reset
        for (int i = 0; i < 600; i++) begin
            rst_n = $urandom_range(0, 59) != 0;
            en    = $urandom_range(0, 7) != 0;
            if ($urandom_range(0, 24) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 9) == 0) period = PW'($urandom_range(0, 5));
            cyc("rand");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern generator for the board bring-up designs. A programmable prescaler divides `clk` into step ticks; on each tick an internal WIDTH-bit pattern advances according to a selectable mode (rotate left, rotate right, bounce, binary count). The pattern drives the LED bank directly, and the prescaler value is exported for GPIO probing.

## Interface
- `WIDTH`, 8: pattern/LED width; must be ≥ 2.
- `PRESC_W`, 27: prescaler and period width.
- `clk  in  1`: the only clock.
- `rst_n  in  1`: reset, synchronous, active-low.
- `en  in  1`: 1 = run; 0 = freeze the prescaler and pattern.
- `mode  in  2`: 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 COUNT.
- `period  in  PRESC_W`: one tick every `period+1` cycles.
- `duty  in  8`: PWM brightness. Used only under `LED_SEQ_PWM_EN`; ignored otherwise.
- `led  out  WIDTH`: pattern, gated by PWM when that feature is enabled.
- `step  out  1`: one-cycle pulse, registered, high in the cycle the pattern updates.
- `count  out  PRESC_W`: current prescaler value.

## Operation
- **Reset** (`rst_n`=0 at a `clk` edge):
  - `count`=0, pattern=1, direction=left, `step`=0, `mode_q`=`mode`.
  - `led`=1 without PWM. With PWM, `led`=1 when `duty`≠0, otherwise 0.
- **Prescaler** (when `en`=1):
  - If `count >= period`: `count`←0 and a tick occurs.
  - Otherwise: `count`←`count+1`.
  - Using `>=` means that lowering `period` below the current `count` ticks on the next edge.
  - `period`=0 gives a tick every cycle.
- **Pattern update on tick**:
  - ROT_L: `p ← {p[W-2:0], p[W-1]}`.
  - ROT_R: `p ← {p[0], p[W-1:1]}`.
  - BOUNCE: a single bit shifts in the current direction. When it reaches bit W-1 the direction flips to right; when it reaches bit 0 it flips to left. The pattern is never held twice at an end: 0x40→0x80→0x40 for W=8.
  - COUNT: `p ← p+1`, modulo 2^WIDTH, so all-ones wraps to 0.
- **Mode change** (`mode`≠`mode_q`):
  - The same edge sets pattern←1, direction←left, `count`←0, `step`←0, `mode_q`←`mode`.
  - It takes priority over a coincident tick and over `en`.
- **`en`=0**: `count`, pattern and direction hold and `step`=0. Mode-change reload still applies.
- **Pattern entering BOUNCE or ROT modes**: always starts one-hot (=1) because of the mode-change reload.
- `led` is combinational from the registered pattern (and the PWM state when enabled).

## Timing
- Tick decision and pattern update share one edge: `step`=1 in the cycle after the edge where `count` equalled `period`, coincident with the new `led` value.
- Steady state: `step` period = `period+1` cycles.
- Latency from a `mode` change to the reloaded pattern on `led`: 1 cycle.
- Latency from deasserting `rst_n` to first `step`: `period+1` cycles, with `en`=1 throughout.

## Configuration
- `LED_SEQ_PWM_EN` defined:
  - Adds an 8-bit free-running `pwm_cnt`: reset 0, increments every cycle, wraps 255→0, and is independent of `en`.
  - `led = pattern & {WIDTH{pwm_cnt < duty}}`.
  - `duty`=0 means always off; `duty`=255 means on for 255 of 256 cycles.
- Not defined:
  - No PWM logic is built.
  - `led = pattern`, and `duty` is unused.

## Structure
- Package `led_seq_pkg`: mode constants `MODE_ROT_L`, `MODE_ROT_R`, `MODE_BOUNCE`, `MODE_COUNT` (2-bit), plus the PWM counter width (8).
- Sub-module `led_seq_presc`:
  - Inputs: `clk`, `rst_n`, `en`, `clr` (mode-change reload), `period`.
  - Outputs: `count` and a `tick` strobe.
  - The top level owns the pattern, direction, `mode_q`, `step` and PWM.

## Test plan
- Reset, WIDTH=8, `period`=3, `mode`=ROT_L, `en`=1: `led`=0x01 and `step` pulses every 4 cycles; `led` runs 0x02, 0x04 … 0x80, 0x01 (wrap).
- `mode`=ROT_R, `period`=0: `led` reloads to 0x01 then goes 0x80, 0x40, … one step per cycle, with `step` held at 1.
- `mode`=BOUNCE, `period`=0: `led` goes 0x01→0x02…0x80→0x40…0x01→0x02, with no repeats at either end.
- `mode`=COUNT from 0xFE: 0xFF then 0x00. Drop `en` for 10 cycles mid-run: `count` and `led` frozen, `step`=0.
- `period`=100, `count`=50, then `period` changed to 10: tick on the next edge and `count`→0. A `mode` change on a tick edge: `led`=0x01, `step`=0.
- With `LED_SEQ_PWM_EN` defined and `duty`=64: `led` nonzero for exactly 64 of every 256 cycles. `duty`=0: `led`=0 always.
